// File: rtl/interp_pkg.sv
// Shared types and elaboration helpers for the interpolate upsampler.
package interp_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } interp_state_t;

    function automatic int phase_w(input int l);
        return $clog2(l);
    endfunction

    function automatic bit is_pow2_ge2(input int l);
        return (l >= 2) && ((l & (l - 1)) == 0);
    endfunction

endpackage

// File: rtl/interp_lerp.sv
// Combinational linear interpolation y = a + floor((b - a) * k / L).
// Only instantiated by interpolate when INTERP_LINEAR_EN is defined.
module interp_lerp
    import interp_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int INTERP_FACTOR = 4
) (
    input  logic signed [WIDTH-1:0]                   a,
    input  logic signed [WIDTH-1:0]                   b,
    input  logic        [phase_w(INTERP_FACTOR)-1:0]  k,
    output logic signed [WIDTH-1:0]                   y
);

    localparam int KW = phase_w(INTERP_FACTOR);
    localparam int PW = WIDTH + 1 + KW;

    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] diff_x;
    logic signed [PW-1:0] k_x;
    logic signed [PW-1:0] prod;

    assign a_x    = PW'(a);
    assign diff_x = PW'(b) - PW'(a);
    assign k_x    = PW'(k);
    assign prod   = diff_x * k_x;

    // The result always lies between a and b, so the truncation is lossless.
    assign y = WIDTH'(a_x + (prod >>> KW));

endmodule

// File: rtl/interpolate.sv
// Upsampler: one low-rate input becomes INTERP_FACTOR outputs, one per out_tick.
// Define INTERP_LINEAR_EN for linear interpolation; otherwise zero-order hold.
module interpolate
    import interp_pkg::*;
#(
    parameter int INTERP_FACTOR = 4,
    parameter int WIDTH         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] data_in,
    output logic                    ready_in,
    input  logic                    out_tick,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    underrun
);

    localparam int KW = phase_w(INTERP_FACTOR);

    generate
        if (!is_pow2_ge2(INTERP_FACTOR)) begin : g_bad_factor
            $error("interpolate: INTERP_FACTOR must be a power of two >= 2");
        end
    endgenerate

    interp_state_t           state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [WIDTH-1:0] a_q, a_d;
    logic signed [WIDTH-1:0] b_q, b_d;
    logic signed [WIDTH-1:0] nxt_q, nxt_d;
    logic                    nxt_full_q, nxt_full_d;
    logic                    valid_out_q, valid_out_d;
    logic signed [WIDTH-1:0] data_out_q, data_out_d;
    logic                    underrun_q, underrun_d;
    logic signed [WIDTH-1:0] interp_y;
    logic                    consume;
    logic                    accept;

`ifdef INTERP_LINEAR_EN
    interp_lerp #(
        .WIDTH         (WIDTH),
        .INTERP_FACTOR (INTERP_FACTOR)
    ) u_lerp (
        .a (a_q),
        .b (b_q),
        .k (k_q),
        .y (interp_y)
    );
`else
    assign interp_y = a_q;
`endif

    // Handshake: the buffer frees up in the very cycle it is consumed.
    assign consume  = out_tick && (state_q == RUN) && (k_q == '0) && nxt_full_q;
    assign ready_in = rst_n && (!nxt_full_q || consume);
    assign accept   = valid_in && ready_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = RUN;
        end
    end

    always_comb begin
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        nxt_d       = nxt_q;
        nxt_full_d  = nxt_full_q;
        valid_out_d = 1'b0;
        data_out_d  = data_out_q;
        underrun_d  = 1'b0;

        if (accept) begin
            nxt_d      = data_in;
            nxt_full_d = 1'b1;
        end else if (consume) begin
            nxt_full_d = 1'b0;
        end

        if ((state_q == RUN) && out_tick) begin
            valid_out_d = 1'b1;
            if (k_q == '0) begin
                // Segment boundary: emit the old end point, then advance if fed.
                data_out_d = b_q;
                if (nxt_full_q) begin
                    a_d = b_q;
                    b_d = nxt_q;
                    k_d = KW'(1);
                end else begin
                    underrun_d = 1'b1;
                end
            end else begin
                data_out_d = interp_y;
                k_d        = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            nxt_q       <= '0;
            nxt_full_q  <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            underrun_q  <= 1'b0;
        end else begin
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            nxt_q       <= nxt_d;
            nxt_full_q  <= nxt_full_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            underrun_q  <= underrun_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_interpolate.sv
// Directed bench for interpolate (L=4, WIDTH=16, out_tick every 4 clk).
// Expected columns cover both builds; INTERP_LINEAR_EN selects the linear one.
module tb_interpolate;

`ifdef INTERP_LINEAR_EN
    localparam bit LIN = 1'b1;
`else
    localparam bit LIN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               valid_in;
    logic signed [15:0] data_in;
    logic               ready_in;
    logic               out_tick;
    logic               valid_out;
    logic signed [15:0] data_out;
    logic               underrun;

    int n_cmp = 0;
    int n_bad = 0;
    int n_tick = 0;
    bit prod_done = 1'b0;

    typedef struct {
        bit uf;
        int lin;
        int zoh;
    } vec_t;

    vec_t vecs[30];
    int   ins[7];

    interpolate #(
        .INTERP_FACTOR (4),
        .WIDTH         (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .out_tick  (out_tick),
        .valid_out (valid_out),
        .data_out  (data_out),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One tick, check the registered output a cycle later and that it is a pulse.
    task automatic tick_chk(input string tag, input bit uf, input int lin, input int zoh);
        int exp;
        exp = LIN ? lin : zoh;
        @(negedge clk);
        out_tick = 1'b1;
        @(negedge clk);
        out_tick = 1'b0;
        n_tick++;
        chk({tag, ".valid"}, int'(valid_out), 1);
        chk({tag, ".data"}, int'(data_out), exp);
        chk({tag, ".uf"}, int'(underrun), int'(uf));
        $display("tick %0d %s: data_out=%0d underrun=%0d (want %0d/%0d)",
                 n_tick, tag, data_out, underrun, exp, uf);
        @(negedge clk);
        chk({tag, ".pulse"}, int'(valid_out), 0);
        @(negedge clk);
    endtask

    task automatic send(input int v, input bit on_tick);
        bit acc = 1'b0;
        bit r;
        bit t = 1'b0;
        int n = 0;
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = 16'(v);
        while (!acc && n < 80) begin
            #4;
            r = ready_in;
            t = out_tick;
            @(posedge clk);
            if (r) acc = 1'b1;
            else @(negedge clk);
            n++;
        end
        #1;
        valid_in = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
        else if (on_tick) chk("accept_on_tick", int'(t), 1);
        $display("send %0d: accepted=%0d", v, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int seen;
        ins  = '{100, 200, 300, 400, -400, 32767, -32768};
        vecs = '{
            '{1'b0, 0, 0},          '{1'b0, 25, 0},        '{1'b0, 50, 0},      '{1'b0, 75, 0},
            '{1'b0, 100, 100},      '{1'b0, 125, 100},     '{1'b0, 150, 100},   '{1'b0, 175, 100},
            '{1'b0, 200, 200},      '{1'b0, 225, 200},     '{1'b0, 250, 200},   '{1'b0, 275, 200},
            '{1'b0, 300, 300},      '{1'b0, 325, 300},     '{1'b0, 350, 300},   '{1'b0, 375, 300},
            '{1'b0, 400, 400},      '{1'b0, 200, 400},     '{1'b0, 0, 400},     '{1'b0, -200, 400},
            '{1'b0, -400, -400},    '{1'b0, 7891, -400},   '{1'b0, 16183, -400}, '{1'b0, 24475, -400},
            '{1'b0, 32767, 32767},  '{1'b0, 16383, 32767}, '{1'b0, -1, 32767}, '{1'b0, -16385, 32767},
            '{1'b1, -32768, -32768}, '{1'b1, -32768, -32768}
        };

        // Reset state: ready_in held low, outputs cleared even with stimulus active.
        rst_n    = 1'b0;
        valid_in = 1'b1;
        data_in  = 16'sd7;
        out_tick = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        chk("reset.ready_in", int'(ready_in), 0);
        @(negedge clk);
        chk("reset.valid_out", int'(valid_out), 0);
        chk("reset.data_out", int'(data_out), 0);
        chk("reset.underrun", int'(underrun), 0);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        out_tick = 1'b0;

        // Ramp, sign/floor corners and backpressure: producer always has data queued.
        fork
            begin
                for (int i = 0; i < 7; i++) send(ins[i], i > 0);
                prod_done = 1'b1;
            end
        join_none
        repeat (2) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            tick_chk($sformatf("stream%0d", i), vecs[i].uf, vecs[i].lin, vecs[i].zoh);
        end
        chk("prod_done", int'(prod_done), 1);

        // Reset mid-segment with data buffered, coinciding with a tick.
        do_reset();
        send(100, 1'b0);
        tick_chk("rst.k0", 1'b0, 0, 0);
        send(200, 1'b0);
        tick_chk("rst.k1", 1'b0, 25, 0);
        @(negedge clk);
        out_tick = 1'b1;
        rst_n    = 1'b0;
        valid_in = 1'b1;
        data_in  = 16'sd999;
        #4;
        chk("midrst.ready_in", int'(ready_in), 0);
        @(negedge clk);
        out_tick = 1'b0;
        rst_n    = 1'b1;
        valid_in = 1'b0;
        chk("midrst.valid_out", int'(valid_out), 0);
        chk("midrst.data_out", int'(data_out), 0);
        chk("midrst.underrun", int'(underrun), 0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            out_tick = (c % 4 == 0);
            if (valid_out || underrun) seen++;
        end
        @(negedge clk);
        out_tick = 1'b0;
        if (valid_out || underrun) seen++;
        chk("empty.ignored_ticks", seen, 0);

        // Underrun and recovery; the ramp restarts from 0.
        send(100, 1'b0);
        tick_chk("ur.k0", 1'b0, 0, 0);
        tick_chk("ur.k1", 1'b0, 25, 0);
        tick_chk("ur.k2", 1'b0, 50, 0);
        tick_chk("ur.k3", 1'b0, 75, 0);
        tick_chk("ur.starve", 1'b1, 100, 100);
        send(500, 1'b0);
        tick_chk("ur.resume0", 1'b0, 100, 100);
        tick_chk("ur.resume1", 1'b0, 200, 100);
        tick_chk("ur.resume2", 1'b0, 300, 100);
        tick_chk("ur.resume3", 1'b0, 400, 100);
        tick_chk("ur.starve2", 1'b1, 500, 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
